sram_ctr_ahb_master: RTL

SRAM_CTR_AHB_MASTER -- requirements
Module: sram_ctr_ahb_master

---
 rtl/sram_ctr_ahb_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sram_ctr_ahb_master.sv
// AHB-Lite burst master: turns a simple command (address, direction, 1..16 beats)
// into pipelined NONSEQ/SEQ transfers, with stall, error and 1 KB boundary handling.
module sram_ctr_ahb_master (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [31:0] wdata_in,
    output logic        wdata_pop,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        done,
    output logic        done_err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic [1:0]  hresp
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [2:0] BURST_SINGLE = 3'b000;
    localparam logic [2:0] BURST_INCR   = 3'b001;
    localparam logic [2:0] SIZE_WORD    = 3'b010;

    state_t      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [2:0]  hburst_q, hburst_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        done_q, done_d;
    logic        done_err_q, done_err_d;
    logic [3:0]  beats_q, beats_d;      // address phases still to issue after the current one
    logic        dphase_q, dphase_d;    // a data phase is outstanding on the bus

    logic [31:0] haddr_next;
    logic        data_ok;
    logic        data_err;

    assign haddr_next = haddr_q + 32'd4;
    assign data_ok    = dphase_q && hready && (hresp == RESP_OKAY);
    // Any non-OKAY response (ERROR, RETRY, SPLIT) starts the two-cycle error sequence.
    assign data_err   = dphase_q && !hready && (hresp != RESP_OKAY);

    // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        haddr_d       = haddr_q;
        htrans_d      = htrans_q;
        hwrite_d      = hwrite_q;
        hsize_d       = hsize_q;
        hburst_d      = hburst_q;
        hwdata_d      = hwdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        done_err_d    = 1'b0;
        beats_d       = beats_q;
        dphase_d      = dphase_q;
        cmd_ready     = 1'b0;
        wdata_pop     = 1'b0;

        if (data_ok && !hwrite_q) begin
            rdata_d       = hrdata;
            rdata_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready = hresetn;
                if (cmd_valid) begin
                    haddr_d  = cmd_addr & 32'hFFFF_FFFC;
                    htrans_d = TRANS_NONSEQ;
                    hwrite_d = cmd_write;
                    hsize_d  = SIZE_WORD;
                    hburst_d = (cmd_len == 4'd0) ? BURST_SINGLE : BURST_INCR;
                    beats_d  = cmd_len;
                    dphase_d = 1'b0;
                    state_d  = S_ADDR;
                end
            end

            S_ADDR: begin
                if (data_err) begin
                    htrans_d = TRANS_IDLE;
                    dphase_d = 1'b0;
                    state_d  = S_ERR;
                end else if (hready) begin
                    wdata_pop = hwrite_q;
                    if (hwrite_q) begin
                        hwdata_d = wdata_in;
                    end
                    dphase_d = 1'b1;
                    if (beats_q == 4'd0) begin
                        htrans_d = TRANS_IDLE;
                        state_d  = S_LAST;
                    end else begin
                        haddr_d = haddr_next;
                        beats_d = beats_q - 4'd1;
                        // Crossing a 1 KB boundary restarts the burst as an undefined-length INCR.
                        if (haddr_next[9:0] == 10'd0) begin
                            htrans_d = TRANS_NONSEQ;
                            hburst_d = BURST_INCR;
                        end else begin
                            htrans_d = TRANS_SEQ;
                        end
                    end
                end
            end

            S_LAST: begin
                if (data_err) begin
                    dphase_d = 1'b0;
                    state_d  = S_ERR;
                end else if (data_ok) begin
                    dphase_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            S_ERR: begin
                if (hready) begin
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q       <= S_IDLE;
            haddr_q       <= 32'd0;
            htrans_q      <= TRANS_IDLE;
            hwrite_q      <= 1'b0;
            hsize_q       <= SIZE_WORD;
            hburst_q      <= BURST_SINGLE;
            hwdata_q      <= 32'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            done_err_q    <= 1'b0;
            beats_q       <= 4'd0;
            dphase_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            haddr_q       <= haddr_d;
            htrans_q      <= htrans_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            hburst_q      <= hburst_d;
            hwdata_q      <= hwdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            done_err_q    <= done_err_d;
            beats_q       <= beats_d;
            dphase_q      <= dphase_d;
        end
    end

    assign haddr       = haddr_q;
    assign htrans      = htrans_q;
    assign hwrite      = hwrite_q;
    assign hsize       = hsize_q;
    assign hburst      = hburst_q;
    assign hwdata      = hwdata_q;
    assign rdata_out   = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign done_err    = done_err_q;

endmodule
